// File: rtl/uart_tx_mmio_if.sv
// CPU load/store bus as seen by the UART transmitter peripheral.
// The master drives address, data and strobes; the slave returns load data.
interface uart_tx_mmio_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        MemWrite;
  logic        MemRead;

  modport master (
    output addr, wdata, MemWrite, MemRead,
    input  rdata
  );

  modport slave (
    input  addr, wdata, MemWrite, MemRead,
    output rdata
  );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXD holds the byte to send and CON holds
// TXIE/TXDONE/TXBUSY. The interrupt request is TXDONE & TXIE.
module uart_tx_mmio #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          BAUD_DIV  = 5208
) (
  input  logic         clk,
  input  logic         reset,
  uart_tx_mmio_if.slave bus,
  output logic         tx,
  output logic         irq
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  localparam logic [31:0] TXD_ADDR  = BASE_ADDR + 32'h0000_0018;
  localparam logic [31:0] CON_ADDR  = BASE_ADDR + 32'h0000_0020;
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);

  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  byte_q, byte_d;
  logic        txie_q, txie_d;
  logic        txdone_q, txdone_d;
  logic        tx_q, tx_d;
  logic        irq_q, irq_d;

  logic hit_txd_s, hit_con_s, busy_s, baud_end_s, done_set_s;
  logic unused_s;

  assign hit_txd_s  = (bus.addr == TXD_ADDR);
  assign hit_con_s  = (bus.addr == CON_ADDR);
  assign busy_s     = (state_q != S_IDLE);
  assign baud_end_s = (baud_q == BAUD_LAST);
  assign unused_s   = ^bus.wdata[31:8];

  assign tx  = tx_q;
  assign irq = irq_q;

  // State register and all architectural flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      baud_q   <= 16'd0;
      bit_q    <= 3'd0;
      byte_q   <= 8'd0;
      txie_q   <= 1'b0;
      txdone_q <= 1'b0;
      tx_q     <= 1'b1;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      txie_q   <= txie_d;
      txdone_q <= txdone_d;
      tx_q     <= tx_d;
      irq_q    <= irq_d;
    end
  end

  // Frame sequencer, register writes and next-cycle line level.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    byte_d     = byte_q;
    done_set_s = 1'b0;

    case (state_q)
      S_IDLE: begin
        // TXD stores while busy fall through here untouched, hence ignored.
        if (bus.MemWrite && hit_txd_s) begin
          state_d = S_START;
          byte_d  = bus.wdata[7:0];
          baud_d  = 16'd0;
          bit_d   = 3'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (baud_end_s) begin
          state_d = S_DATA;
          baud_d  = 16'd0;
          bit_d   = 3'd0;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (baud_end_s) begin
          baud_d = 16'd0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_STOP: begin
        if (baud_end_s) begin
          state_d    = S_IDLE;
          baud_d     = 16'd0;
          done_set_s = 1'b1;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = 16'd0;
        bit_d   = 3'd0;
      end
    endcase

    if (bus.MemWrite && hit_con_s) begin
      txie_d = bus.wdata[0];
    end else begin
      txie_d = txie_q;
    end

    // A completing frame beats a simultaneous clearing read.
    if (done_set_s) begin
      txdone_d = 1'b1;
    end else if (bus.MemRead && hit_con_s) begin
      txdone_d = 1'b0;
    end else begin
      txdone_d = txdone_q;
    end

    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = byte_d[bit_d];
      default: tx_d = 1'b1;
    endcase

    irq_d = txdone_d & txie_d;
  end

  // Combinational load path for the single-cycle core.
  always_comb begin
    if (hit_txd_s) begin
      bus.rdata = {24'd0, byte_q};
    end else if (hit_con_s) begin
      bus.rdata = {27'd0, busy_s, 1'b0, txdone_q, 1'b0, txie_q};
    end else begin
      bus.rdata = 32'd0;
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio with BAUD_DIV=4: register table plus
// scoreboarded serial frames compared cycle by cycle on the tx line.
module tb_uart_tx_mmio;
  localparam int          BD   = 4;
  localparam logic [31:0] BASE = 32'h4000_0000;
  localparam logic [31:0] TXD  = 32'h4000_0018;
  localparam logic [31:0] CON  = 32'h4000_0020;

  logic clk;
  logic reset;
  logic tx;
  logic irq;
  logic mon_en;

  int n_vec;
  int n_err;

  logic exp_q[$];

  uart_tx_mmio_if bus ();

  uart_tx_mmio #(.BASE_ADDR(BASE), .BAUD_DIV(BD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .tx    (tx),
    .irq   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every cycle the tx line is compared against the scoreboard, or idle-high.
  always @(posedge clk) begin
    logic e;
    #2;
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("tx_frame", {31'd0, tx}, {31'd0, e});
      end else begin
        chk("tx_idle", {31'd0, tx}, 32'd1);
      end
    end
  end

  task automatic push_frame(input logic [7:0] b);
    for (int i = 0; i < BD; i++) exp_q.push_back(1'b0);
    for (int k = 0; k < 8; k++)
      for (int i = 0; i < BD; i++) exp_q.push_back(b[k]);
    for (int i = 0; i < BD; i++) exp_q.push_back(1'b1);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input bit accept);
    bus.addr     = a;
    bus.wdata    = d;
    bus.MemWrite = 1'b1;
    if (accept) push_frame(d[7:0]);
    @(negedge clk);
    bus.MemWrite = 1'b0;
    bus.addr     = 32'd0;
  endtask

  task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
    bus.addr    = a;
    bus.MemRead = 1'b1;
    #1;
    chk(nm, bus.rdata, exp);
    @(negedge clk);
    bus.MemRead = 1'b0;
    bus.addr    = 32'd0;
  endtask

  // Returns at the negedge in the final STOP cycle (queue drained).
  task automatic wait_q_empty();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      chk("frame_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    mon_en       = 1'b0;
    reset        = 1'b0;
    bus.addr     = 32'd0;
    bus.wdata    = 32'd0;
    bus.MemWrite = 1'b0;
    bus.MemRead  = 1'b0;

    tbl[0] = '{1'b0, 1'b1, CON,                  32'd0,          32'd0};
    tbl[1] = '{1'b0, 1'b1, TXD,                  32'd0,          32'd0};
    tbl[2] = '{1'b0, 1'b1, BASE,                 32'd0,          32'd0};
    tbl[3] = '{1'b1, 1'b0, CON,                  32'hFFFF_FFFF,  32'd0};
    tbl[4] = '{1'b0, 1'b1, CON,                  32'd0,          32'h0000_0001};
    tbl[5] = '{1'b0, 1'b1, 32'h4000_001C,        32'd0,          32'd0};
    tbl[6] = '{1'b1, 1'b0, 32'h4000_0024,        32'h0000_00FF,  32'd0};
    tbl[7] = '{1'b1, 1'b0, CON,                  32'hFFFF_FFFE,  32'h0000_0001};
    tbl[8] = '{1'b0, 1'b1, CON,                  32'd0,          32'd0};
    tbl[9] = '{1'b0, 1'b1, 32'h4000_0118,        32'd0,          32'd0};

    repeat (3) @(negedge clk);
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    reset  = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      bus.addr     = tbl[i].addr;
      bus.wdata    = tbl[i].wdata;
      bus.MemWrite = tbl[i].we;
      bus.MemRead  = tbl[i].re;
      #1;
      chk($sformatf("table_%0d", i), bus.rdata, tbl[i].exp);
      @(negedge clk);
      bus.MemWrite = 1'b0;
      bus.MemRead  = 1'b0;
    end

    // 0xA5 frame, with an ignored TXD store in the middle.
    store(TXD, 32'h0000_00A5, 1'b1);
    repeat (5) @(negedge clk);
    rd("con_busy", CON, 32'h0000_0010);
    store(TXD, 32'h0000_003C, 1'b0);
    rd("txd_keep", TXD, 32'h0000_00A5);
    wait_q_empty();
    @(negedge clk);
    rd("con_done", CON, 32'h0000_0004);
    rd("con_clr", CON, 32'h0000_0000);
    repeat (10) @(negedge clk);

    // Interrupt path with 0x55.
    store(CON, 32'h0000_0001, 1'b0);
    store(TXD, 32'h0000_0055, 1'b1);
    wait_q_empty();
    chk("irq_before_end", {31'd0, irq}, 32'd0);
    @(negedge clk);
    chk("irq_rise", {31'd0, irq}, 32'd1);
    rd("con_irq", CON, 32'h0000_0005);
    chk("irq_fall", {31'd0, irq}, 32'd0);
    rd("con_ie_only", CON, 32'h0000_0001);
    store(CON, 32'h0000_0000, 1'b0);

    // Back-to-back frames: store in the first IDLE cycle after STOP.
    store(TXD, 32'h0000_000F, 1'b1);
    wait_q_empty();
    @(negedge clk);
    store(TXD, 32'h0000_00F0, 1'b1);
    wait_q_empty();
    @(negedge clk);
    rd("con_b2b", CON, 32'h0000_0004);
    rd("txd_b2b", TXD, 32'h0000_00F0);

    // Reset during DATA bit 3 of 0xFF.
    store(TXD, 32'h0000_00FF, 1'b1);
    repeat (17) @(negedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk("async_tx", {31'd0, tx}, 32'd1);
    bus.addr = CON;
    #1;
    chk("async_idle", bus.rdata, 32'd0);
    bus.addr = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    rd("rst_txd", TXD, 32'd0);
    store(TXD, 32'h0000_0081, 1'b1);
    wait_q_empty();
    @(negedge clk);
    rd("con_81", CON, 32'h0000_0004);
    rd("txd_81", TXD, 32'h0000_0081);
    repeat (3) @(negedge clk);

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_mmio.md
Name: uart_tx_mmio

Overview:
- Memory-mapped UART transmitter for the single-cycle MIPS core; acts as responder to CPU load/store cycles in the 0x4000_00xx peripheral window.
- Firmware writes a byte to UART_TXD and then polls or takes an interrupt on UART_CON.
- Serialises 8N1 frames on the tx pin at a divided bit rate.

Parameters:
- BASE_ADDR, 32'h4000_0000, base of the peripheral window.
- BAUD_DIV, 5208, clk cycles per bit (50 MHz / 9600 baud); legal range 2..65535.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- addr  input  32  CPU data address, word aligned.
- wdata  input  32  CPU store data.
- MemWrite  input  1  store strobe, one cycle per store.
- MemRead  input  1  load strobe.
- rdata  output  32  load data; combinational from addr and register state.
- tx  output  1  serial line, idle high.
- irq  output  1  transmit-done interrupt request to the core.

Behaviour:
- Register map, decoded on addr[31:0] == BASE_ADDR + offset:
  - 0x18 UART_TXD: write loads wdata[7:0]. Read returns {24'b0, last accepted byte}.
  - 0x20 UART_CON: bit0 TXIE (R/W). bit2 TXDONE (RO, clear-on-read). bit4 TXBUSY (RO). Other bits read 0, and writes to them are ignored.
  - Any other address: rdata = 0, writes ignored.
- Reset (reset == 0, asynchronous): state IDLE; tx=1; irq=0; TXIE=0; TXDONE=0; TXBUSY=0; data byte=0; baud and bit counters=0.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on the clock edge where MemWrite is high, addr hits TXD, and state is IDLE. The byte is latched and TXBUSY=1 at that same edge, so tx falls low one cycle after the store.
  - START: tx=0 for BAUD_DIV cycles, then DATA with bit index 0.
  - DATA: tx=byte[index], LSB first, BAUD_DIV cycles per bit. After index 7 completes, go to STOP.
  - STOP: tx=1 for BAUD_DIV cycles. At the final cycle go to IDLE, set TXBUSY=0 and TXDONE=1.
- Frame length: exactly 10*BAUD_DIV cycles from the first tx low cycle to return to IDLE.
- Baud counter runs 0..BAUD_DIV-1, resets on every state change, and is 16 bits wide.
- TXD write while TXBUSY=1: ignored. The latched byte, frame and TXD readback are unchanged, and no error is flagged.
- TXDONE clear: cleared on the clock edge of a load cycle (MemRead high) to UART_CON. rdata in that cycle shows the pre-clear value.
  - If TXDONE is being set and cleared on the same edge, set wins.
- Store to UART_CON updates TXIE from wdata[0] only. It does not affect TXDONE or TXBUSY.
- irq = TXDONE & TXIE, registered-source combinational; deasserts the cycle after the clearing read.
- Back-to-back frames: a TXD write in the first IDLE cycle after STOP is accepted. This gives a minimum gap of one clk cycle of idle-high.
- Reset asserted mid-frame: tx returns high immediately (async) and the frame is abandoned.
- rdata is valid whenever addr decodes, independent of MemRead, which supports the single-cycle core's combinational load path.

Test Plan:
- Reset, then release with BAUD_DIV=4 -> tx=1, irq=0; read 0x4000_0020 returns 0x0000_0000.
- Store 0x0000_00A5 to 0x4000_0018 -> tx low from the next cycle for 4 cycles. Then data bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high for 4 cycles. UART_CON reads 0x10 during the frame and 0x04 after.
- Store 0x3C to TXD mid-frame of 0xA5 -> frame bits unchanged; TXD readback still 0xA5; no second frame starts.
- Store 0x1 to UART_CON, then send 0x55 -> irq rises at frame end. Load of UART_CON returns 0x05 and irq=0 the next cycle; a second read returns 0x01.
- Store TXD on the first IDLE cycle after the STOP of 0x0F, with byte 0xF0 -> second START begins with exactly one idle-high cycle between frames; both frames are bit-exact.
- Assert reset during DATA bit 3 of 0xFF -> tx=1 asynchronously and state IDLE. After release, a new store of 0x81 transmits cleanly.
